// File: rtl/data_bus_decoder.sv
// Core data-port decoder: steers each access to RAM, ROM port B or the peripheral
// bus, tracks the single outstanding access and returns a one-cycle ready/err pulse.
module data_bus_decoder #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] ROM_BASE = 32'h0000_0000,
    parameter logic [XLEN-1:0] RAM_BASE = 32'h1000_0000,
    parameter logic [XLEN-1:0] PER_BASE = 32'h2000_0000,
    parameter int              MEM_LAT  = 1,
    parameter int              TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            c_req,
    input  logic            c_we,
    input  logic [XLEN-1:0] c_addr,
    input  logic [3:0]      c_byteen,
    input  logic [XLEN-1:0] c_wdata,
    output logic [XLEN-1:0] c_rdata,
    output logic            c_ready,
    output logic            c_err,
    output logic [14:0]     ram_addr,
    output logic [3:0]      ram_byteen,
    output logic            ram_we,
    output logic [XLEN-1:0] ram_wdata,
    input  logic [XLEN-1:0] ram_rdata,
    output logic [15:0]     rom_addr,
    output logic            rom_rden,
    input  logic [XLEN-1:0] rom_rdata,
    output logic            per_req,
    output logic            per_we,
    output logic [15:0]     per_addr,
    output logic [3:0]      per_byteen,
    output logic [XLEN-1:0] per_wdata,
    input  logic [XLEN-1:0] per_rdata,
    input  logic            per_ack
);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, PER_WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        lat_q, lat_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              sel_rom_q, sel_rom_d;

    logic hit_rom, hit_ram, hit_per;
    logic sel_rom, sel_ram, sel_per;
    logic illegal, unmapped, accept, good;
    logic [XLEN-1:0] mem_data;
    logic unused_addr_bits;

    // Windows are checked in priority order ROM, RAM, peripheral.
    assign hit_rom  = (c_addr[XLEN-1:18] == ROM_BASE[XLEN-1:18]);
    assign hit_ram  = (c_addr[XLEN-1:17] == RAM_BASE[XLEN-1:17]);
    assign hit_per  = (c_addr[XLEN-1:18] == PER_BASE[XLEN-1:18]);
    assign sel_rom  = hit_rom;
    assign sel_ram  = !hit_rom && hit_ram;
    assign sel_per  = !hit_rom && !hit_ram && hit_per;
    assign unmapped = !(hit_rom || hit_ram || hit_per);
    assign illegal  = (c_byteen == 4'b0000) || (sel_rom && c_we);
    assign accept   = (state_q == IDLE) && c_req;
    assign good     = accept && !illegal && !unmapped;

    assign unused_addr_bits = ^c_addr[1:0];

    assign ram_addr   = c_addr[16:2];
    assign ram_byteen = c_byteen;
    assign ram_wdata  = c_wdata;
    assign rom_addr   = c_addr[17:2];
    assign per_we     = c_we;
    assign per_addr   = c_addr[17:2];
    assign per_byteen = c_byteen;
    assign per_wdata  = c_wdata;

    // Strobes are gated by rst so they fall the instant reset asserts.
    assign ram_we   = !rst && good && sel_ram && c_we;
    assign rom_rden = !rst && good && sel_rom && !c_we;
    assign per_req  = !rst && ((state_q == PER_WAIT) || (good && sel_per));

    assign mem_data = sel_rom_q ? rom_rdata : ram_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lat_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            sel_rom_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            sel_rom_q <= sel_rom_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        sel_rom_d = sel_rom_q;
        c_ready   = 1'b0;
        c_err     = 1'b0;
        c_rdata   = rdata_q;
        case (state_q)
            IDLE: begin
                if (c_req) begin
                    if (illegal || unmapped) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else if (sel_per) begin
                        cnt_d   = 16'd1;
                        state_d = PER_WAIT;
                    end else if (c_we) begin
                        err_d   = 1'b0;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        sel_rom_d = sel_rom;
                        lat_d     = 2'd0;
                        state_d   = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                // Synchronous slave data is forwarded combinationally on the ready cycle.
                if (lat_q == 2'(MEM_LAT - 1)) begin
                    c_ready = 1'b1;
                    c_rdata = mem_data;
                    rdata_d = mem_data;
                    lat_d   = 2'd0;
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            PER_WAIT: begin
                // cnt_q equals the number of cycles since the request was issued.
                if (per_ack) begin
                    rdata_d = c_we ? '0 : per_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q >= 16'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                c_ready = 1'b1;
                c_err   = err_q;
                err_d   = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_bus_decoder.sv
// Directed bench for data_bus_decoder with simple RAM/ROM slave models and a
// hand-driven peripheral; TIMEOUT is set to 8 cycles.
module tb_data_bus_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req = 1'b0;
    logic        c_we = 1'b0;
    logic [31:0] c_addr = '0;
    logic [3:0]  c_byteen = '0;
    logic [31:0] c_wdata = '0;
    logic [31:0] c_rdata;
    logic        c_ready, c_err;
    logic [14:0] ram_addr;
    logic [3:0]  ram_byteen;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [15:0] rom_addr;
    logic        rom_rden;
    logic [31:0] rom_rdata = '0;
    logic        per_req, per_we;
    logic [15:0] per_addr;
    logic [3:0]  per_byteen;
    logic [31:0] per_wdata;
    logic [31:0] per_rdata = '0;
    logic        per_ack = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [31:0] ram_mem [0:31];

    always #5 clk = ~clk;

    data_bus_decoder #(.MEM_LAT(1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_byteen(c_byteen),
        .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ready(c_ready), .c_err(c_err),
        .ram_addr(ram_addr), .ram_byteen(ram_byteen), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .rom_addr(rom_addr), .rom_rden(rom_rden), .rom_rdata(rom_rdata),
        .per_req(per_req), .per_we(per_we), .per_addr(per_addr),
        .per_byteen(per_byteen), .per_wdata(per_wdata), .per_rdata(per_rdata),
        .per_ack(per_ack)
    );

    // Slave models: RAM with byte-enable writes and registered read, ROM returns a tagged address.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_we && ram_byteen[b]) ram_mem[ram_addr[4:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= ram_mem[ram_addr[4:0]];
        rom_rdata <= {16'hA5A5, rom_addr};
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
        c_req = 1'b1; c_we = we; c_addr = addr; c_byteen = be; c_wdata = wd;
    endtask

    task automatic drop_req();
        c_req = 1'b0; c_we = 1'b0;
    endtask

    task automatic test_reset();
        start(1'b0, 32'h0000_0100, 4'hF, 32'h0);
        @(negedge clk);
        checks++; if (c_ready !== 1'b0 || c_err !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b/%b exp=0/0", c_ready, c_err); end
        checks++; if (c_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", c_rdata); end
        checks++; if ({ram_we, rom_rden, per_req} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {ram_we, rom_rden, per_req}); end
        next_cycle();
        drop_req();
        rst = 1'b0;
        next_cycle();
        $display("txn reset released");
    endtask

    task automatic test_ram();
        start(1'b1, 32'h1000_0010, 4'hF, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++; if (ram_we !== 1'b1 || ram_addr !== 15'h0004) begin failures++; $display("FAIL ram_wr_strobe got=%b addr=%h exp=1 addr=0004", ram_we, ram_addr); end
        checks++; if (c_ready !== 1'b0) begin failures++; $display("FAIL ram_wr_early_ready got=%b exp=0", c_ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (c_ready !== 1'b1 || c_err !== 1'b0 || c_rdata !== 32'h0) begin failures++; $display("FAIL ram_wr_resp got=%b/%b/%h exp=1/0/00000000", c_ready, c_err, c_rdata); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL ram_wr_pulse got=%b exp=0", ram_we); end
        $display("txn ram write addr=10000010 data=deadbeef");
        next_cycle();
        start(1'b0, 32'h1000_0010, 4'hF, 32'h0);
        @(negedge clk);
        checks++; if (ram_we !== 1'b0 || c_ready !== 1'b0) begin failures++; $display("FAIL ram_rd_issue got=%b/%b exp=0/0", ram_we, c_ready); end
        next_cycle();
        drop_req();
        @(negedge clk);
        checks++; if (c_ready !== 1'b1 || c_err !== 1'b0 || c_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rd_resp got=%b/%b/%h exp=1/0/deadbeef", c_ready, c_err, c_rdata); end
        next_cycle();
        @(negedge clk);
        checks++; if (c_ready !== 1'b0 || c_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rd_hold got=%b/%h exp=0/deadbeef", c_ready, c_rdata); end
        $display("txn ram read addr=10000010 data=%h", c_rdata);
        next_cycle();
    endtask

    task automatic test_rom();
        start(1'b0, 32'h0000_0100, 4'hF, 32'h0);
        @(negedge clk);
        checks++; if (rom_rden !== 1'b1 || rom_addr !== 16'h0040) begin failures++; $display("FAIL rom_strobe got=%b addr=%h exp=1 addr=0040", rom_rden, rom_addr); end
        checks++; if (ram_we !== 1'b0 || per_req !== 1'b0) begin failures++; $display("FAIL rom_other_strobes got=%b/%b exp=0/0", ram_we, per_req); end
        next_cycle();
        drop_req();
        @(negedge clk);
        checks++; if (c_ready !== 1'b1 || c_err !== 1'b0 || c_rdata !== 32'hA5A5_0040) begin failures++; $display("FAIL rom_resp got=%b/%b/%h exp=1/0/a5a50040", c_ready, c_err, c_rdata); end
        checks++; if (rom_rden !== 1'b0) begin failures++; $display("FAIL rom_pulse got=%b exp=0", rom_rden); end
        $display("txn rom read addr=00000100 data=%h", c_rdata);
        next_cycle();
    endtask

    task automatic test_per_read();
        start(1'b0, 32'h2000_0008, 4'hF, 32'h0);
        @(negedge clk);
        checks++; if (per_req !== 1'b1 || per_addr !== 16'h0002) begin failures++; $display("FAIL per_issue got=%b addr=%h exp=1 addr=0002", per_req, per_addr); end
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (per_req !== 1'b1 || c_ready !== 1'b0) begin failures++; $display("FAIL per_wait got=%b/%b exp=1/0", per_req, c_ready); end
        next_cycle();
        per_ack = 1'b1; per_rdata = 32'h55;
        @(negedge clk);
        checks++; if (per_req !== 1'b1 || c_ready !== 1'b0) begin failures++; $display("FAIL per_ack_cycle got=%b/%b exp=1/0", per_req, c_ready); end
        next_cycle();
        per_ack = 1'b0; per_rdata = 32'h0;
        drop_req();
        @(negedge clk);
        checks++; if (c_ready !== 1'b1 || c_err !== 1'b0 || c_rdata !== 32'h55) begin failures++; $display("FAIL per_resp got=%b/%b/%h exp=1/0/00000055", c_ready, c_err, c_rdata); end
        checks++; if (per_req !== 1'b0) begin failures++; $display("FAIL per_req_drop got=%b exp=0", per_req); end
        $display("txn per read addr=20000008 data=%h", c_rdata);
        next_cycle();
    endtask

    task automatic test_per_timeout();
        start(1'b1, 32'h2000_0000, 4'hF, 32'h1234);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (per_req !== 1'b1 || c_ready !== 1'b0) begin failures++; $display("FAIL to_wait_%0d got=%b/%b exp=1/0", k, per_req, c_ready); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (c_ready !== 1'b1 || c_err !== 1'b1 || c_rdata !== 32'h0) begin failures++; $display("FAIL to_resp got=%b/%b/%h exp=1/1/00000000", c_ready, c_err, c_rdata); end
        checks++; if (per_req !== 1'b0) begin failures++; $display("FAIL to_req_drop got=%b exp=0", per_req); end
        next_cycle();
        drop_req();
        next_cycle();
        next_cycle();
        next_cycle();
        per_ack = 1'b1; per_rdata = 32'hFFFF;
        @(negedge clk);
        checks++; if (c_ready !== 1'b0 || per_req !== 1'b0) begin failures++; $display("FAIL to_late_ack got=%b/%b exp=0/0", c_ready, per_req); end
        next_cycle();
        per_ack = 1'b0;
        @(negedge clk);
        checks++; if (c_ready !== 1'b0 || c_err !== 1'b0) begin failures++; $display("FAIL to_late_ack_after got=%b/%b exp=0/0", c_ready, c_err); end
        $display("txn per write timeout addr=20000000");
        next_cycle();
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3] = '{32'h3000_0000, 32'h0000_0100, 32'h1000_0000};
        logic        wes   [3] = '{1'b0, 1'b1, 1'b0};
        logic [3:0]  bes   [3] = '{4'hF, 4'hF, 4'h0};
        for (int i = 0; i < 3; i++) begin
            start(wes[i], addrs[i], bes[i], 32'hCAFE_F00D);
            @(negedge clk);
            checks++; if ({ram_we, rom_rden, per_req, c_ready} !== 4'b0000) begin failures++; $display("FAIL err%0d_strobes got=%b exp=0000", i, {ram_we, rom_rden, per_req, c_ready}); end
            next_cycle();
            drop_req();
            @(negedge clk);
            checks++; if (c_ready !== 1'b1 || c_err !== 1'b1 || c_rdata !== 32'h0) begin failures++; $display("FAIL err%0d_resp got=%b/%b/%h exp=1/1/00000000", i, c_ready, c_err, c_rdata); end
            $display("txn error access addr=%h we=%b be=%h", addrs[i], wes[i], bes[i]);
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        start(1'b0, 32'h2000_0004, 4'hF, 32'h0);
        next_cycle();
        @(negedge clk);
        checks++; if (per_req !== 1'b1) begin failures++; $display("FAIL rstmid_per_pre got=%b exp=1", per_req); end
        rst = 1'b1;
        #1;
        checks++; if (per_req !== 1'b0) begin failures++; $display("FAIL rstmid_per_drop got=%b exp=0", per_req); end
        next_cycle();
        drop_req();
        @(negedge clk);
        checks++; if (c_ready !== 1'b0) begin failures++; $display("FAIL rstmid_per_ready got=%b exp=0", c_ready); end
        rst = 1'b0;
        next_cycle();
        start(1'b0, 32'h0000_0200, 4'hF, 32'h0);
        @(negedge clk);
        checks++; if (rom_rden !== 1'b1) begin failures++; $display("FAIL rstmid_rom_pre got=%b exp=1", rom_rden); end
        rst = 1'b1;
        #1;
        checks++; if (rom_rden !== 1'b0) begin failures++; $display("FAIL rstmid_rom_drop got=%b exp=0", rom_rden); end
        next_cycle();
        drop_req();
        rst = 1'b0;
        next_cycle();
        start(1'b0, 32'h0000_0200, 4'hF, 32'h0);
        next_cycle();
        rst = 1'b1;
        #1;
        checks++; if (c_ready !== 1'b0) begin failures++; $display("FAIL rstmid_memwait_ready got=%b exp=0", c_ready); end
        next_cycle();
        drop_req();
        rst = 1'b0;
        next_cycle();
        start(1'b0, 32'h0000_0200, 4'hF, 32'h0);
        next_cycle();
        drop_req();
        @(negedge clk);
        checks++; if (c_ready !== 1'b1 || c_err !== 1'b0 || c_rdata !== 32'hA5A5_0080) begin failures++; $display("FAIL rstmid_nominal got=%b/%b/%h exp=1/0/a5a50080", c_ready, c_err, c_rdata); end
        $display("txn reset mid-access then rom read data=%h", c_rdata);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ram();
        test_rom();
        test_per_read();
        test_per_timeout();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
